// File: rtl/search_dispatcher.sv
// ==== search_dispatcher : launches LANES collision-search lanes, arbitrates first hit ====
// ==== Rev 1.0 | optional run budget via SEARCH_DISPATCHER_TIMEOUT_EN                 ====
`default_nettype none

module search_dispatcher #(
   parameter int LANES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  cancel,
   input  logic [31:0]           base_counter,
   input  logic [31:0]           max_cycles,
   output logic [LANES-1:0]      lane_start,
   output logic [32*LANES-1:0]   lane_counter,
   output logic [31:0]           lane_increment,
   output logic [LANES-1:0]      lane_abort,
   input  logic [LANES-1:0]      lane_done,
   input  logic [32*LANES-1:0]   lane_result,
   input  logic [32*LANES-1:0]   lane_digests,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic                  timed_out,
   output logic                  cancelled,
   output logic [31:0]           result,
   output logic [2:0]            winner,
   output logic [31:0]           total_digests
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_ABORT  = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   state_t      state, state_next;
   logic        hit;
   logic [2:0]  hit_idx;
   logic [31:0] hit_result;
   logic [31:0] digest_sum;
   logic        timeout_hit;

   // Descending scan so the lowest asserted lane wins.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = 3'd0;
      hit_result = 32'd0;
      digest_sum = 32'd0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (lane_done[i]) begin
            hit        = 1'b1;
            hit_idx    = 3'(i);
            hit_result = lane_result[32*i +: 32];
         end
      end
      for (int i = 0; i < LANES; i++) begin
         digest_sum = digest_sum + lane_digests[32*i +: 32];
      end
   end

`ifdef SEARCH_DISPATCHER_TIMEOUT_EN
   logic [31:0] max_latched;
   logic [31:0] run_cycles;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_latched <= 32'd0;
         run_cycles  <= 32'd0;
      end else begin
         if (state == S_IDLE && start)
            max_latched <= max_cycles;
         if (state == S_LAUNCH)
            run_cycles <= 32'd0;
         else if (state == S_RUN)
            run_cycles <= run_cycles + 32'd1;
      end
   end

   assign timeout_hit = (max_latched != 32'd0) && (run_cycles == max_latched - 32'd1);
`else
   logic unused_max_cycles;
   assign unused_max_cycles = ^max_cycles;
   assign timeout_hit       = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_LAUNCH;
         S_LAUNCH: state_next = S_RUN;
         S_RUN:    if (hit || cancel || timeout_hit) state_next = S_ABORT;
         S_ABORT:  state_next = S_REPORT;
         S_REPORT: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Strobes are registered from next state so each lands in the cycle of its state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         lane_start     <= '0;
         lane_abort     <= '0;
         lane_counter   <= '0;
         lane_increment <= 32'd0;
         found          <= 1'b0;
         timed_out      <= 1'b0;
         cancelled      <= 1'b0;
         result         <= 32'd0;
         winner         <= 3'd0;
         total_digests  <= 32'd0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != S_IDLE);
         done       <= (state_next == S_REPORT);
         lane_start <= (state_next == S_LAUNCH) ? '1 : '0;
         lane_abort <= (state_next == S_ABORT)  ? '1 : '0;

         if (state == S_IDLE && start) begin
            for (int i = 0; i < LANES; i++)
               lane_counter[32*i +: 32] <= base_counter + 32'(i);
            lane_increment <= 32'(LANES);
            found          <= 1'b0;
            timed_out      <= 1'b0;
            cancelled      <= 1'b0;
            result         <= 32'd0;
            winner         <= 3'd0;
            total_digests  <= 32'd0;
         end

         if (state == S_RUN) begin
            if (hit) begin
               found         <= 1'b1;
               winner        <= hit_idx;
               result        <= hit_result;
               total_digests <= digest_sum;
            end else if (cancel) begin
               cancelled     <= 1'b1;
               total_digests <= digest_sum;
            end else if (timeout_hit) begin
               timed_out     <= 1'b1;
               total_digests <= digest_sum;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_search_dispatcher.sv
// Directed self-checking bench for search_dispatcher with LANES=4.
`default_nettype none

module tb_search_dispatcher;

   localparam int LANES = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                cancel;
   logic [31:0]         base_counter;
   logic [31:0]         max_cycles;
   logic [LANES-1:0]    lane_start;
   logic [32*LANES-1:0] lane_counter;
   logic [31:0]         lane_increment;
   logic [LANES-1:0]    lane_abort;
   logic [LANES-1:0]    lane_done;
   logic [32*LANES-1:0] lane_result;
   logic [32*LANES-1:0] lane_digests;
   logic                busy, done, found, timed_out, cancelled;
   logic [31:0]         result;
   logic [2:0]          winner;
   logic [31:0]         total_digests;

   int checks   = 0;
   int failures = 0;

   search_dispatcher #(.LANES(LANES)) dut (
      .clk(clk), .reset(reset), .start(start), .cancel(cancel),
      .base_counter(base_counter), .max_cycles(max_cycles),
      .lane_start(lane_start), .lane_counter(lane_counter),
      .lane_increment(lane_increment), .lane_abort(lane_abort),
      .lane_done(lane_done), .lane_result(lane_result), .lane_digests(lane_digests),
      .busy(busy), .done(done), .found(found), .timed_out(timed_out),
      .cancelled(cancelled), .result(result), .winner(winner),
      .total_digests(total_digests)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [31:0] base);
      base_counter = base;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
   endtask

   int runs;

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      cancel       = 1'b0;
      base_counter = 32'd0;
      max_cycles   = 32'd0;
      lane_done    = '0;
      lane_result  = '0;
      lane_digests = {32'd10, 32'd12, 32'd11, 32'd10};
      lane_result[32*2 +: 32] = 32'h20A;
      lane_result[32*1 +: 32] = 32'h55;
      lane_result[32*3 +: 32] = 32'h77;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_counter", lane_counter, 0);
      check("rst_start", lane_start, 0);
      check("rst_incr", lane_increment, 0);
      reset = 1'b0;

      // lane_done in IDLE must not wake the block
      lane_done = 4'b0001;
      @(negedge clk);
      check("idle_done_ignored", busy, 0);
      lane_done = '0;

      // Basic launch and lane-2 hit
      launch(32'h100);
      check("launch_start", lane_start, 4'b1111);
      check("launch_counter", lane_counter, {32'h103, 32'h102, 32'h101, 32'h100});
      check("launch_incr", lane_increment, 32'd4);
      check("launch_busy", busy, 1);
      @(negedge clk);
      check("run_start_low", lane_start, 0);
      lane_done = 4'b0100;
      @(negedge clk);
      lane_done = '0;
      check("abort_strobe", lane_abort, 4'b1111);
      check("abort_no_done", done, 0);
      @(negedge clk);
      check("report_done", done, 1);
      check("report_abort_low", lane_abort, 0);
      check("report_found", found, 1);
      check("report_winner", winner, 3'd2);
      check("report_result", result, 32'h20A);
      check("report_digests", total_digests, 32'd43);
      @(negedge clk);
      check("idle_done_low", done, 0);
      check("idle_busy_low", busy, 0);
      check("hold_result", result, 32'h20A);

      // Wraparound base, start ignored mid-run, done beats cancel
      launch(32'hFFFF_FFFE);
      check("wrap_counter", lane_counter, {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      check("launch_clears_found", found, 0);
      base_counter = 32'h1234;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      check("start_ignored_run", lane_counter, {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      lane_done = 4'b1010;
      cancel    = 1'b1;
      @(negedge clk);
      lane_done = '0;
      cancel    = 1'b0;
      @(negedge clk);
      check("prio_done", done, 1);
      check("prio_found", found, 1);
      check("prio_winner", winner, 3'd1);
      check("prio_result", result, 32'h55);
      check("prio_cancelled", cancelled, 0);
      @(negedge clk);

      // Cancel alone
      launch(32'h40);
      @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel_abort", lane_abort, 4'b1111);
      @(negedge clk);
      check("cancel_done", done, 1);
      check("cancel_flag", cancelled, 1);
      check("cancel_found", found, 0);
      check("cancel_digests", total_digests, 32'd43);
      @(negedge clk);

      // Run budget of 5 cycles
      max_cycles = 32'd5;
      launch(32'h0);
      runs = 0;
`ifdef SEARCH_DISPATCHER_TIMEOUT_EN
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (lane_abort == 4'b1111) break;
         runs++;
      end
      check("timeout_run_cycles", runs, 5);
      @(negedge clk);
      check("timeout_done", done, 1);
      check("timeout_flag", timed_out, 1);
      check("timeout_found", found, 0);
      @(negedge clk);
`else
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (lane_abort == 4'b1111) runs++;
      end
      check("no_timeout_abort", runs, 0);
      check("no_timeout_busy", busy, 1);
      check("no_timeout_flag", timed_out, 0);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      repeat (2) @(negedge clk);
`endif

      // Reset in RUN clears everything immediately, no done pulse afterwards
      launch(32'h900);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_counter", lane_counter, 0);
      check("midrst_incr", lane_increment, 0);
      check("midrst_abort", lane_abort, 0);
      @(negedge clk);
      reset = 1'b0;
      runs = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (done) runs++;
      end
      check("midrst_no_done", runs, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/search_dispatcher.md
SEARCH_DISPATCHER -- requirements
Module: search_dispatcher

Interface
REQ-001 SHALL have parameter LANES, default 4: number of collision-search lanes driven; legal values 2, 4, 8.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a new search; sampled in IDLE only.
REQ-005 SHALL have port cancel, input, 1: abandon the running search.
REQ-006 SHALL have port base_counter, input, 32: first counter value of the search.
REQ-007 SHALL have port max_cycles, input, 32: RUN-cycle budget; 0 means unlimited.
REQ-008 SHALL have port lane_start, output, LANES: per-lane start strobe.
REQ-009 SHALL have port lane_counter, output, 32*LANES: per-lane base counter; lane i occupies bits [32i+31:32i].
REQ-010 SHALL have port lane_increment, output, 32: shared counter stride.
REQ-011 SHALL have port lane_abort, output, LANES: per-lane registered abort strobe, wired to the lane's reset.
REQ-012 SHALL have port lane_done, input, LANES: per-lane done pulse.
REQ-013 SHALL have port lane_result, input, 32*LANES: per-lane result counter.
REQ-014 SHALL have port lane_digests, input, 32*LANES: per-lane digests-computed count.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port found, timed_out and cancelled, outputs, 1 each: completion cause.
REQ-018 SHALL have port result, output, 32: winning counter value.
REQ-019 SHALL have port winner, output, 3: winning lane index.
REQ-020 SHALL have port total_digests, output, 32: sum of all lane digest counts at completion.

Function
REQ-021 SHALL implement the states IDLE, LAUNCH, RUN, ABORT and REPORT.
REQ-022 SHALL behave as follows in IDLE: start=1 latches base_counter and max_cycles, then moves to LAUNCH.
REQ-023 SHALL behave as follows in LAUNCH (exactly 1 cycle): lane_start is all ones, then the block moves to RUN.
REQ-024 SHALL drive lane_counter[i] = base_latched + i, modulo 2^32, and hold it stable from LAUNCH until the next start.
REQ-025 SHALL drive lane_increment = LANES, zero-extended to 32 bits.
REQ-026 SHALL behave as follows in RUN: run_cycles clears on entry and increments once per RUN cycle.
REQ-027 SHALL move from RUN to ABORT on the RUN cycle where any lane_done bit is high.
  - In that same cycle it captures winner = lowest set index, result = that lane's lane_result, found=1, and total_digests = the modulo-2^32 sum of all lane_digests.
REQ-028 SHALL move from RUN to ABORT when no lane_done is high and cancel=1; it sets cancelled=1 and captures total_digests the same way.
REQ-029 SHALL set timed_out=1 and move to ABORT when no lane_done is high, cancel=0, max_cycles≠0, and run_cycles = max_cycles-1, so RUN lasts exactly max_cycles cycles.
REQ-030 SHALL apply this priority when events coincide in one cycle: lane_done > cancel > timeout.
REQ-031 SHALL behave as follows in ABORT (exactly 1 cycle): lane_abort is all ones, then the block moves to REPORT.
REQ-032 SHALL behave as follows in REPORT (exactly 1 cycle): done=1, then the block moves to IDLE.
REQ-033 SHALL hold result, winner, found, timed_out, cancelled and total_digests from REPORT until the next LAUNCH, and clear them on LAUNCH.
REQ-034 SHALL ignore start in every state except IDLE, and ignore cancel outside RUN.
REQ-035 SHALL give this latency: start sampled at edge k gives lane_start high in cycle k+1; lane_done high in RUN cycle n gives lane_abort in n+1 and done in n+2.
REQ-036 SHALL ignore lane_done bits arriving outside RUN.
REQ-037 SHALL register all outputs; no output is combinationally derived from an input.

Reset
REQ-038 SHALL on reset assertion immediately force: state=IDLE, every output=0, lane_counter=0, and internal latches and run_cycles=0.
REQ-039 SHALL on reset asserted mid-search abandon the search with no done pulse; lane_abort stays 0 because the lanes share reset.

Configuration
REQ-040 SHALL support the macro SEARCH_DISPATCHER_TIMEOUT_EN.
  - Defined: max_cycles budget and timed_out behave per REQ-029.
  - Undefined: the max_cycles port remains, is ignored, timed_out is tied 0, and no run_cycles counter is built.

Verification
REQ-041 SHALL cover: LANES=4, base=0x100, start → lane_start=4'b1111 one cycle, lane_counter=0x100/0x101/0x102/0x103, lane_increment=4.
REQ-042 SHALL cover: lane_done=4'b0100, lane2 result=0x20A, lane_digests=10/11/12/10 → abort=4'b1111 next cycle, then done, found=1, winner=2, result=0x20A, total_digests=43.
REQ-043 SHALL cover: lane_done=4'b1010 and cancel=1 in the same cycle → found=1, winner=1, cancelled=0.
REQ-044 SHALL cover (macro defined): max_cycles=5, no lane_done → exactly 5 RUN cycles, then timed_out=1, found=0, done pulse.
REQ-045 SHALL cover: base=0xFFFFFFFE → lane_counter=0xFFFFFFFE/0xFFFFFFFF/0x0/0x1; and reset asserted in RUN → all outputs 0 immediately, no done pulse.
